// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frames are start, LSB-first data,
// optional parity and one or two stop bits, sent back-to-back while words remain.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          txd,
  output logic                          busy
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : badParams
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr, rdPtr;
  logic                 push, pop;
  logic [AW:0]          levelNext;
  logic [DATA_BITS-1:0] head;

  assign push      = wr_en && !full;
  assign levelNext = level + (AW + 1)'(push) - (AW + 1)'(pop);
  assign head      = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      // full/empty come from the same next-level value, so they never disagree with level.
      level    <= levelNext;
      full     <= (levelNext == DEPTH_L);
      empty    <= (levelNext == '0);
      overflow <= wr_en && full;
    end
  end

  // NOTE: storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wrPtr] <= wr_data;
  end

  // ---------------- Transmit FSM ----------------
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} stateT;

  stateT                state, nextState;
  logic [CW-1:0]        cycleCnt, nextCycle;
  logic [3:0]           bitCnt, nextBit;
  logic [DATA_BITS-1:0] shiftReg, nextShift;
  logic                 parityBit, nextParity;
  logic                 nextTxd;
  logic                 bitDone;
  logic                 loadWord;

  assign bitDone = (cycleCnt == CYC_LAST);
  assign busy    = (state != IDLE);

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    nextState  = state;
    nextCycle  = cycleCnt;
    nextBit    = bitCnt;
    nextShift  = shiftReg;
    nextParity = parityBit;
    nextTxd    = txd;
    loadWord   = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        nextTxd  = 1'b1;
        loadWord = !empty;
      end
      START: begin
        if (bitDone) begin
          nextState = DATA;
          nextCycle = '0;
          nextBit   = '0;
          nextTxd   = shiftReg[0];
        end else nextCycle = cycleCnt + 1'b1;
      end
      DATA: begin
        if (bitDone) begin
          nextCycle = '0;
          nextShift = shiftReg >> 1;
          if (bitCnt == DATA_LAST) begin
            nextBit = '0;
            if (PARITY != 0) begin
              nextState = PAR;
              nextTxd   = parityBit;
            end else begin
              nextState = STOP;
              nextTxd   = 1'b1;
            end
          end else begin
            nextBit = bitCnt + 1'b1;
            nextTxd = shiftReg[1];
          end
        end else nextCycle = cycleCnt + 1'b1;
      end
      PAR: begin
        if (bitDone) begin
          nextState = STOP;
          nextCycle = '0;
          nextBit   = '0;
          nextTxd   = 1'b1;
        end else nextCycle = cycleCnt + 1'b1;
      end
      STOP: begin
        if (bitDone) begin
          nextCycle = '0;
          if (bitCnt == STOP_LAST) begin
            // Chain straight into the next frame when a word is waiting.
            if (!empty) loadWord = 1'b1;
            else begin
              nextState = IDLE;
              nextTxd   = 1'b1;
            end
          end else nextBit = bitCnt + 1'b1;
        end else nextCycle = cycleCnt + 1'b1;
      end
      default: nextState = IDLE;
    endcase
    if (loadWord) begin
      pop        = 1'b1;
      nextShift  = head;
      nextParity = (^head) ^ (PARITY == 2);
      nextState  = START;
      nextCycle  = '0;
      nextBit    = '0;
      nextTxd    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cycleCnt  <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      txd       <= 1'b1;
    end else begin
      state     <= nextState;
      cycleCnt  <= nextCycle;
      bitCnt    <= nextBit;
      shiftReg  <= nextShift;
      parityBit <= nextParity;
      txd       <= nextTxd;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three variants (8N1, 8E2, 8O1) share one stimulus and are
// compared every cycle against a queue-and-timeline reference model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [2:0] full, empty, overflow, txd, busy;
  logic [2:0] level [3];

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dutN (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[0]),
    .empty(empty[0]), .level(level[0]), .overflow(overflow[0]), .txd(txd[0]), .busy(busy[0]));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dutE (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[1]),
    .empty(empty[1]), .level(level[1]), .overflow(overflow[1]), .txd(txd[1]), .busy(busy[1]));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dutO (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[2]),
    .empty(empty[2]), .level(level[2]), .overflow(overflow[2]), .txd(txd[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  bit chkEn = 1'b0;

  // Reference model: FIFO as a ring of words, transmitter as "frame of word W began at cycle S".
  int         mCnt [3];
  int         mHead [3];
  int         mStart [3];
  bit         mAct [3];
  bit         mOvf [3];
  logic [7:0] mMem [3][4];
  logic [7:0] mWord [3];

  function automatic int parOf(int id);
    return id;
  endfunction

  function automatic int stopOf(int id);
    return (id == 1) ? 2 : 1;
  endfunction

  function automatic int frameLen(int id);
    return 10 * (1 + 8 + ((parOf(id) != 0) ? 1 : 0) + stopOf(id));
  endfunction

  function automatic logic expTxd(int id);
    int         j;
    logic [7:0] w;
    if (!mAct[id]) return 1'b1;
    j = (t - mStart[id]) / 10;
    w = mWord[id];
    if (j == 0) return 1'b0;
    if (j <= 8) return w[j-1];
    if (parOf(id) != 0 && j == 9) return (^w) ^ (parOf(id) == 2);
    return 1'b1;
  endfunction

  task automatic modelReset(int id);
    mCnt[id] = 0; mHead[id] = 0; mAct[id] = 1'b0; mOvf[id] = 1'b0; mStart[id] = 0;
  endtask

  task automatic modelUpdate(int id, bit wr, logic [7:0] d, bit rst);
    bit lastCycle, popNow, pushNow;
    if (!rst) begin
      modelReset(id);
      return;
    end
    lastCycle = mAct[id] && (t == mStart[id] + frameLen(id) - 1);
    popNow    = (mCnt[id] > 0) && (!mAct[id] || lastCycle);
    pushNow   = wr && (mCnt[id] < 4);
    mOvf[id]  = wr && (mCnt[id] == 4);
    if (popNow) begin
      mWord[id]  = mMem[id][mHead[id]];
      mHead[id]  = (mHead[id] + 1) % 4;
      mCnt[id]   = mCnt[id] - 1;
      mStart[id] = t + 1;
      mAct[id]   = 1'b1;
    end else if (lastCycle) mAct[id] = 1'b0;
    if (pushNow) begin
      mMem[id][(mHead[id] + mCnt[id]) % 4] = d;
      mCnt[id] = mCnt[id] + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      if (bad <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(int id);
    string p;
    p = $sformatf("t%0d dut%0d", t, id);
    check({p, " txd"},      32'(txd[id]),      32'(expTxd(id)));
    check({p, " busy"},     32'(busy[id]),     32'(mAct[id]));
    check({p, " level"},    32'(level[id]),    32'(mCnt[id]));
    check({p, " full"},     32'(full[id]),     32'(mCnt[id] == 4));
    check({p, " empty"},    32'(empty[id]),    32'(mCnt[id] == 0));
    check({p, " overflow"}, 32'(overflow[id]), 32'(mOvf[id]));
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, advance the model, cross the edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit rst);
    wr_en   = wr;
    wr_data = d;
    rst_n   = rst;
    @(negedge clk);
    if (chkEn) for (int id = 0; id < 3; id++) checkModel(id);
    for (int id = 0; id < 3; id++) modelUpdate(id, wr, d, rst);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic runTo(input int n);
    while (t < n) step(1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic doReset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    t = 0;
  endtask

  logic [7:0] words [6];
  int         burst;

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    for (int id = 0; id < 3; id++) modelReset(id);
    repeat (2) @(posedge clk);
    #1;
    chkEn = 1'b1;
    t     = 0;

    // Reset state
    check("reset txd",   32'(txd),   32'h7);
    check("reset empty", 32'(empty), 32'h7);
    check("reset busy",  32'(busy),  32'h0);

    // Single 0xA5 frame in all three formats
    step(1'b1, 8'hA5, 1'b1);
    runTo(2);   check("a5 start low",    32'(txd[0]),  32'h0);
    runTo(12);  check("a5 bit0",         32'(txd[0]),  32'h1);
    runTo(22);  check("a5 bit1",         32'(txd[0]),  32'h0);
    runTo(92);  check("a5 stop",         32'(txd[0]),  32'h1);
                check("a5 even parity",  32'(txd[1]),  32'h0);
                check("a5 odd parity",   32'(txd[2]),  32'h1);
    runTo(101); check("a5 busy last",    32'(busy[0]), 32'h1);
    runTo(102); check("a5 busy fall",    32'(busy[0]), 32'h0);
    runTo(112); check("8o1 busy fall",   32'(busy[2]), 32'h0);
    runTo(121); check("8e2 busy 2nd stop", 32'(busy[1]), 32'h1);
                check("8e2 2nd stop high", 32'(txd[1]),  32'h1);
    runTo(122); check("8e2 busy fall",   32'(busy[1]), 32'h0);
    runTo(130);

    // Back-to-back frames with no idle gap
    doReset();
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    runTo(101); check("b2b stop",        32'(txd[0]),  32'h1);
    runTo(102); check("b2b second start", 32'(txd[0]), 32'h0);
                check("b2b busy",        32'(busy[0]), 32'h1);
    runTo(112); check("b2b ff bit0",     32'(txd[0]),  32'h1);
    runTo(210);

    // Fill past capacity: five accepted, sixth dropped
    doReset();
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) step(1'b1, words[i], 1'b1);
    check("ovf full at 6",   32'(full[0]),     32'h1);
    check("ovf pulse",       32'(overflow[0]), 32'h1);
    check("ovf level",       32'(level[0]),    32'h4);
    runTo(7);
    check("ovf pulse ends",  32'(overflow[0]), 32'h0);
    runTo(620);
    check("ovf drained",     32'(empty),       32'h7);

    // Reset in the middle of the first of three queued frames
    doReset();
    step(1'b1, 8'h3C, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    runTo(50);
    step(1'b1, 8'h77, 1'b0);
    check("rst txd",   32'(txd),   32'h7);
    check("rst busy",  32'(busy),  32'h0);
    check("rst level", 32'(level[0]), 32'h0);
    runTo(200);
    check("rst stays idle", 32'(busy), 32'h0);

    // Random traffic with bursts and one asynchronous-to-traffic reset pulse
    doReset();
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 7);
      if (i == 700) step(1'b1, 8'($urandom), 1'b0);
      else if (burst > 0) begin
        step(1'b1, 8'($urandom), 1'b1);
        burst--;
      end else step($urandom_range(0, 99) < 3, 8'($urandom), 1'b1);
    end
    runTo(t + 800);
    check("random drained", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: a power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port wr_en, input, 1: write request into the FIFO.
REQ-010 SHALL have port wr_data, input, DATA_BITS: the word to transmit.
REQ-011 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port empty, output, 1: FIFO holds 0 words.
REQ-013 SHALL have port level, output, clog2(FIFO_DEPTH)+1: current FIFO word count.
REQ-014 SHALL have port overflow, output, 1: one-cycle pulse when a write is dropped.
REQ-015 SHALL have port txd, output, 1: serial line, idle high.
REQ-016 SHALL have port busy, output, 1: a frame is in progress.

Function
REQ-017 SHALL use CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD, integer; elaboration SHALL fail if this is < 2 or if any parameter is outside its legal range.
REQ-018 SHALL make full, empty and level registered and mutually consistent every cycle.
REQ-019 SHALL accept a write when wr_en=1 and full=0; level SHALL increment the next cycle unless a pop occurs in the same cycle, in which case level is unchanged.
REQ-020 SHALL drop a write when wr_en=1 and full=1, even if a pop occurs in the same cycle; overflow SHALL pulse high for exactly the next cycle and FIFO contents SHALL stay unchanged.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PAR and STOP, with a bit counter and a cycle counter modulo CLKS_PER_BIT.
REQ-022 SHALL, in IDLE with empty=0, pop the head word into a shift register that cycle and enter START next cycle.
REQ-023 SHALL, for a write to an empty FIFO at cycle W while IDLE, pop at W+1 and drive txd low from W+2.
REQ-024 SHALL hold every bit (start, data, parity, stop) on txd for exactly CLKS_PER_BIT cycles.
REQ-025 SHALL drive txd=0 in START, data bits LSB first in DATA, and txd=1 in STOP for STOP_BITS bit times.
REQ-026 SHALL skip PAR when PARITY=0; otherwise the parity bit SHALL be the XOR of the data bits for PARITY=1 and its inverse for PARITY=2.
REQ-027 SHALL, in the last cycle of the final stop bit, pop the next word if empty=0 and enter START next cycle (no idle gap); otherwise it SHALL return to IDLE.
REQ-028 SHALL make the frame length exactly CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-029 SHALL assert busy in all states except IDLE; txd SHALL be registered and glitch-free.
REQ-030 SHALL not corrupt a frame in flight when wr_data changes after its write is accepted.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, on the next cycle force: state IDLE; txd=1; busy=0; empty=1; full=0; level=0; overflow=0; all counters 0; FIFO contents discarded.
REQ-032 SHALL, on reset mid-frame, abort the frame with txd high from the next cycle; no resumption after rst_n returns high.
REQ-033 SHALL ignore wr_en in every cycle where rst_n=0.

Verification
All scenarios use CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10), FIFO_DEPTH=4 unless stated otherwise.
REQ-034 SHALL cover 8N1, write 0xA5 at cycle 0: txd low cycles 2-11, then 10-cycle bits 1,0,1,0,0,1,0,1, then high cycles 92-101; busy falls at cycle 102.
REQ-035 SHALL cover PARITY=1 with 0xA5: parity bit 0 at cycles 92-101; PARITY=2 with 0xA5: parity bit 1; STOP_BITS=2: stop high for 20 cycles, then busy=0.
REQ-036 SHALL cover back-to-back 0x00, 0xFF written at cycles 0 and 1: second start bit begins exactly at cycle 102; txd never idles between frames.
REQ-037 SHALL cover writes on cycles 0-5 with txd idle at start: level reaches 4 with full=1 at cycle 5; the write at cycle 5 is dropped with overflow=1 at cycle 6; the transmitted words are writes 0-4 in order.
REQ-038 SHALL cover rst_n low at cycle 50 during the first frame of 3 queued words: txd=1, level=0, busy=0 at cycle 51; no further frames after rst_n=1.
